// File: rtl/spi_master_9bit.sv
// spi_master_9bit
// ---------------------------------------------------------------------------
// Frame-level SPI master for a W-bit SPI slave stage. A frame is started
// with a one-cycle start request. The master then:
//   - raises LOAD so the slave loads DI;
//   - shifts tx_data out MSB-first on MOSI while sampling MISO into rx_data;
//   - optionally raises LOAD a second time so the slave latches the word it
//     received onto DO.
// All outputs are registered.
//
// Parameters:
//   W    frame width in bits (must match the slave shift register)
//   DIV  CLK cycles per SCLK half-period, 1..255
//
// Ports:
//   CLK      system clock, all logic on its rising edge
//   clr      asynchronous active-high reset
//   start    frame request, honoured only while idle
//   tx_data  word to transmit, captured when start is accepted
//   busy     high while a frame is in progress
//   done     one-cycle pulse in the first idle cycle after a frame
//   rx_data  word received on MISO, updated only at frame end
//   SCLK     SPI clock to the slave, idles low
//   MOSI     serial data to the slave
//   LOAD     slave load/latch strobe, active-high
//   MISO     serial data from the slave
//
// Build option:
//   SPI_MASTER_TRAIL_LOAD_EN  When defined, a trailing LOAD half-period is
//                             added so the slave latches DO at frame end.
//                             When undefined, the frame ends with the final
//                             SCLK fall and the slave's DO only updates at
//                             the next frame's leading LOAD.
// ---------------------------------------------------------------------------
module spi_master_9bit #(
  parameter int W   = 9,
  parameter int DIV = 4
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] tx_data,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rx_data,
  output logic         SCLK,
  output logic         MOSI,
  output logic         LOAD,
  input  logic         MISO
);

  localparam int            BW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

`ifdef SPI_MASTER_TRAIL_LOAD_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    TRAIL    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEAD     = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3
  } state_t;
`endif

  state_t        state_r;
  logic [W-1:0]  txsr_r;
  logic [W-1:0]  rxsr_r;
  logic [BW-1:0] bit_cnt_r;
  logic [7:0]    div_cnt_r;
  logic          half_end_s;

  // Last CLK cycle of the current half-period.
  assign half_end_s = (div_cnt_r == 8'd0);

  // Frame sequencer: state, shift registers, counters and all outputs.
  always_ff @(posedge CLK or posedge clr) begin
    if (clr) begin
      state_r   <= IDLE;
      txsr_r    <= '0;
      rxsr_r    <= '0;
      bit_cnt_r <= '0;
      div_cnt_r <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= '0;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      LOAD      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            txsr_r    <= tx_data;
            bit_cnt_r <= BIT_LAST;
            div_cnt_r <= DIV_LAST;
            MOSI      <= tx_data[W-1];
            LOAD      <= 1'b1;
            busy      <= 1'b1;
            state_r   <= LEAD;
          end
        end
        LEAD: begin
          if (half_end_s) begin
            LOAD      <= 1'b0;
            div_cnt_r <= DIV_LAST;
            state_r   <= SHIFT_LO;
          end else begin
            div_cnt_r <= div_cnt_r - 8'd1;
          end
        end
        SHIFT_LO: begin
          if (half_end_s) begin
            // MISO is sampled on the edge that raises SCLK, using the value
            // the slave has been driving since the previous SCLK fall.
            SCLK      <= 1'b1;
            rxsr_r    <= {rxsr_r[W-2:0], MISO};
            div_cnt_r <= DIV_LAST;
            state_r   <= SHIFT_HI;
          end else begin
            div_cnt_r <= div_cnt_r - 8'd1;
          end
        end
        SHIFT_HI: begin
          if (half_end_s) begin
            SCLK      <= 1'b0;
            txsr_r    <= {txsr_r[W-2:0], 1'b0};
            div_cnt_r <= DIV_LAST;
            if (bit_cnt_r == '0) begin
`ifdef SPI_MASTER_TRAIL_LOAD_EN
              LOAD    <= 1'b1;
              state_r <= TRAIL;
`else
              // No trailing LOAD: the final SCLK-low half overlaps the
              // return to idle, so the frame closes on this edge.
              rx_data <= rxsr_r;
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= IDLE;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r - {{(BW-1){1'b0}}, 1'b1};
              MOSI      <= txsr_r[W-2];
              state_r   <= SHIFT_LO;
            end
          end else begin
            div_cnt_r <= div_cnt_r - 8'd1;
          end
        end
`ifdef SPI_MASTER_TRAIL_LOAD_EN
        TRAIL: begin
          if (half_end_s) begin
            LOAD    <= 1'b0;
            rx_data <= rxsr_r;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            div_cnt_r <= div_cnt_r - 8'd1;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          SCLK    <= 1'b0;
          LOAD    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_9bit.sv
// Scoreboard bench for spi_master_9bit. Two instances run side by side:
// one with DIV=4 and one with DIV=1. Each instance has its own behavioural
// slave, stimulus process and monitor. The stimulus pushes one expected
// frame record per accepted start; the monitor pops and compares at every
// done pulse.
module tb_spi_master_9bit;
  localparam int W = 9;

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] rx;
    int           blen;
    int           loads;
    logic [W-1:0] dox;
    logic         dochk;
  } rec_t;

  int   checks   = 0;
  int   failures = 0;
  logic CLK      = 1'b0;

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int div, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s div=%0d actual=%0h required=%0h", name, div, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int DV = (g == 0) ? 4 : 1;
`ifdef SPI_MASTER_TRAIL_LOAD_EN
    localparam int   BLEN     = (2 * W + 2) * DV;
    localparam int   NLOAD    = 2;
    localparam logic TRAIL_ON = 1'b1;
`else
    localparam int   BLEN     = (2 * W + 1) * DV;
    localparam int   NLOAD    = 1;
    localparam logic TRAIL_ON = 1'b0;
`endif
    localparam logic [W-1:0] TX0 = (g == 0) ? 9'h1A5 : 9'h155;
    localparam logic [W-1:0] DI0 = (g == 0) ? 9'h0C3 : 9'h0AA;

    logic         clr, start, busy, done, SCLK, MOSI, LOAD, MISO;
    logic [W-1:0] tx_data, rx_data;
    logic         fin = 1'b0;

    spi_master_9bit #(.W(W), .DIV(DV)) dut (
      .CLK(CLK), .clr(clr), .start(start), .tx_data(tx_data),
      .busy(busy), .done(done), .rx_data(rx_data),
      .SCLK(SCLK), .MOSI(MOSI), .LOAD(LOAD), .MISO(MISO)
    );

    // Behavioural slave: LOAD rise latches the shift register onto DO and
    // reloads it from DI; MOSI sampled on SCLK rise, shifted in on SCLK fall.
    logic [W-1:0] di = '0, sr = '0, do_w = '0;
    logic         samp = 1'b0;
    assign MISO = sr[W-1];
    always @(posedge LOAD) begin
      #1;
      do_w = sr;
      sr   = di;
    end
    always @(posedge SCLK) samp = MOSI;
    always @(negedge SCLK) sr = {sr[W-2:0], samp};

    // Reference model state and expected-frame queue.
    rec_t         exp_q[$];
    logic [W-1:0] prev_tx = '0;
    logic         prev_ok = 1'b1;

    task automatic accept(input logic [W-1:0] t, input logic [W-1:0] d);
      rec_t r;
      di      = d;
      r.tx    = t;
      r.rx    = d;
      r.blen  = BLEN;
      r.loads = NLOAD;
      r.dox   = TRAIL_ON ? t : prev_tx;
      r.dochk = TRAIL_ON ? 1'b1 : prev_ok;
      exp_q.push_back(r);
      prev_tx = t;
      prev_ok = 1'b1;
    endtask

    task automatic cyc_drive(input logic s, input logic [W-1:0] t, input logic [W-1:0] d);
      @(negedge CLK);
      start   = s;
      tx_data = t;
      if (s && !busy && !clr) accept(t, d);
    endtask

    task automatic issue(input logic [W-1:0] t, input logic [W-1:0] d);
      cyc_drive(1'b1, t, d);
      cyc_drive(1'b0, t, d);
    endtask

    task automatic wait_idle();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 4 * BLEN) begin
        @(negedge CLK);
        n++;
      end
      chk("idle_timeout", DV, 32'(n < 4 * BLEN), 32'd1);
      @(negedge CLK);
    endtask

    // Monitor: accumulates per-frame observations, compares on done.
    int           bcnt = 0, lcnt = 0, lhi = 0, scnt = 0, cyc = 0, last_rise = 0;
    int           gap_bad = 0, mosi_bad = 0, hold_bad = 0;
    logic [W-1:0] mword = '0, last_rx = '0;
    logic         ps = 1'b0, pl = 1'b0, pm = 1'b0, pd = 1'b0;
    rec_t         mrec;

    always @(negedge CLK) begin
      cyc++;
      if (pd) chk("done_pulse", DV, 32'(done), 32'd0);
      if (clr) begin
        bcnt = 0; lcnt = 0; lhi = 0; scnt = 0; mword = '0;
        gap_bad = 0; mosi_bad = 0; hold_bad = 0; last_rx = rx_data;
      end else begin
        if (busy) bcnt++;
        if (LOAD) lhi++;
        if (LOAD && !pl) lcnt++;
        if (SCLK && !ps) begin
          if (scnt > 0 && (cyc - last_rise) != 2 * DV) gap_bad++;
          last_rise = cyc;
          scnt++;
          mword = {mword[W-2:0], MOSI};
        end
        if (SCLK && ps && MOSI !== pm) mosi_bad++;
        if (done) begin
          chk("done_expected", DV, 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            mrec = exp_q.pop_front();
            chk("rx_data", DV, 32'(rx_data), 32'(mrec.rx));
            chk("busy_len", DV, bcnt, mrec.blen);
            chk("mosi_word", DV, 32'(mword), 32'(mrec.tx));
            chk("sclk_rises", DV, scnt, W);
            chk("sclk_spacing", DV, gap_bad, 0);
            chk("mosi_stable", DV, mosi_bad, 0);
            chk("load_pulses", DV, lcnt, mrec.loads);
            chk("load_cycles", DV, lhi, mrec.loads * DV);
            chk("busy_at_done", DV, 32'(busy), 32'd0);
            chk("rx_hold", DV, hold_bad, 0);
            if (mrec.dochk) chk("slave_do", DV, 32'(do_w), 32'(mrec.dox));
          end
          bcnt = 0; lcnt = 0; lhi = 0; scnt = 0; mword = '0;
          gap_bad = 0; mosi_bad = 0; hold_bad = 0; last_rx = rx_data;
        end else if (rx_data !== last_rx) begin
          hold_bad++;
        end
      end
      ps = SCLK; pl = LOAD; pm = MOSI; pd = done;
    end

    // Stimulus.
    initial begin : drv
      logic [W-1:0] t, d;
      int           n, dcnt;
      clr = 1'b1; start = 1'b0; tx_data = '0;
      repeat (2) @(negedge CLK);
      chk("reset_busy", DV, 32'(busy), 32'd0);
      chk("reset_done", DV, 32'(done), 32'd0);
      chk("reset_rx", DV, 32'(rx_data), 32'd0);
      chk("reset_sclk", DV, 32'(SCLK), 32'd0);
      chk("reset_load", DV, 32'(LOAD), 32'd0);
      chk("reset_mosi", DV, 32'(MOSI), 32'd0);
      clr = 1'b0;
      @(negedge CLK);

      // Basic frame.
      issue(TX0, DI0);
      wait_idle();

      // Start while busy is ignored.
      issue(9'h0FF, 9'h123);
      repeat (10) cyc_drive(1'b1, 9'h100, 9'h1FF);
      cyc_drive(1'b0, 9'h100, 9'h1FF);
      wait_idle();
      chk("no_extra_frame", DV, 32'(busy), 32'd0);

      // Back-to-back frames with start held high.
      d = 9'($urandom_range(0, 511));
      cyc_drive(1'b1, 9'h001, d);
      @(negedge CLK);
      n = 0;
      while (busy && n < 2 * BLEN) begin
        @(negedge CLK);
        n++;
      end
      chk("b2b_done_cycle", DV, 32'(done), 32'd1);
      tx_data = 9'h1FE;
      if (!busy) accept(9'h1FE, 9'($urandom_range(0, 511)));
      @(negedge CLK);
      chk("b2b_restart", DV, 32'(busy), 32'd1);
      start = 1'b0;
      wait_idle();

      // Reset in the middle of a SHIFT_HI half-period.
      t = 9'h100 | 9'($urandom_range(0, 255));
      issue(t, 9'($urandom_range(0, 511)));
      n = 0;
      while (!SCLK && n < BLEN) begin
        @(negedge CLK);
        n++;
      end
      chk("reach_shift_hi", DV, 32'(SCLK), 32'd1);
      clr = 1'b1;
      #1;
      chk("clr_busy", DV, 32'(busy), 32'd0);
      chk("clr_done", DV, 32'(done), 32'd0);
      chk("clr_rx", DV, 32'(rx_data), 32'd0);
      chk("clr_sclk", DV, 32'(SCLK), 32'd0);
      chk("clr_load", DV, 32'(LOAD), 32'd0);
      chk("clr_mosi", DV, 32'(MOSI), 32'd0);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      prev_ok = 1'b0;
      repeat (3) @(negedge CLK);
      clr  = 1'b0;
      dcnt = 0;
      repeat (BLEN + 8) begin
        @(negedge CLK);
        if (done) dcnt++;
      end
      chk("no_done_after_clr", DV, dcnt, 0);

      // Randomised frames with random idle gaps.
      for (int i = 0; i < 6; i++) begin
        t = 9'($urandom_range(0, 511));
        d = 9'($urandom_range(0, 511));
        issue(t, d);
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
      fin = 1'b1;
    end
  end

  initial begin : summary
    int n = 0;
    while (!(inst[0].fin && inst[1].fin) && n < 30000) begin
      @(posedge CLK);
      n++;
    end
    chk("global_timeout", 0, 32'(n < 30000), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
